alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Buffered result stage directly downstream of the 8-bit ALU. Captures each ALU result (opcode, 2×DATA_W-bit result, carry flag) on a valid/ready push handshake and presents entries in order to the consumer on a first-word-fall-through valid/ready pop interface. Decouples the combinational ALU from a consumer that may stall, and flags lost results with a sticky overflow bit.

## Interface
- `DATA_W`, 8, ALU operand width; the stored result is 2×DATA_W bits
- `DEPTH`, 4, number of entries; a power of two, ≥2
- `clk`  in  1  rising-edge clock, the only clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  producer presents an ALU result this cycle
- `in_op`  in  4  ALU opcode associated with the result
- `in_result`  in  2×DATA_W  ALU result
- `in_carry`  in  1  ALU carry flag
- `in_ready`  out  1  FIFO can accept an entry (= not full)
- `out_valid`  out  1  head entry available
- `out_op`  out  4  head opcode
- `out_result`  out  2×DATA_W  head result
- `out_carry`  out  1  head carry flag
- `out_zero`  out  1  head result was zero (present only with `ALU_RES_ZERO_FLAG_EN`)
- `out_ready`  in  1  consumer takes the head entry this cycle
- `count`  out  clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- `overflow`  out  1  sticky: a push was attempted while full
- `clr_ovf`  in  1  synchronous clear of `overflow`

## Operation
- Storage: DEPTH-entry register array; write and read pointers are clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
- Empty: pointers are equal. Full: low bits are equal and wrap bits differ.
- Push: `in_valid && in_ready` at a rising edge writes {op, result, carry} at wptr, then wptr increments modulo 2×DEPTH.
- Pop: `out_valid && out_ready` at a rising edge increments rptr.
- `in_ready = !full` combinationally. There is no same-cycle pass-through when full: a push is refused even if a pop occurs in the same cycle.
- Push while full (`in_valid && !in_ready`):
  - the entry is dropped;
  - `overflow` sets at that edge and holds until `clr_ovf` or reset.
  - If `clr_ovf` and a dropped push coincide, set wins.
- Simultaneous push and pop when neither empty nor full: both occur and `count` is unchanged.
- Push into an empty FIFO: no combinational bypass; the entry appears on the output after the edge.
- `out_valid = !empty`. The `out_*` data fields show mem[rptr] when `out_valid`=1 and are forced to 0 when `out_valid`=0.
- Data is never checked or modified; the result is stored bit-exact at full 2×DATA_W width.

## Timing
- Reset (async assert, release synchronised to `clk` by the system):
  - rptr=wptr=0, `count`=0, `overflow`=0;
  - `out_valid`=0, `out_op`=0, `out_result`=0, `out_carry`=0, `out_zero`=0;
  - `in_ready`=1.
  - Memory contents are not reset.
- Reset mid-operation discards all stored entries immediately; `out_valid` falls asynchronously.
- Push-to-output latency: an entry pushed at edge N is visible with `out_valid`=1 in the cycle after edge N.
- After a pop at edge N from a full FIFO, `in_ready` is 1 in the cycle after edge N.
- `count` is a registered output and updates at the same edge as the pointers.
- Pointer wrap: after 2×DEPTH pushes and pops, the pointers return to 0 with no loss of ordering.

## Configuration
- `ALU_RES_ZERO_FLAG_EN` defined:
  - each entry stores an extra bit equal to (`in_result` == 0), computed at push;
  - the `out_zero` port exists, is forced to 0 when empty and resets to 0.
- Not defined: the `out_zero` port and its storage bit are absent; all other behaviour is identical.

## Test plan
- Reset, then push op=4'h2, result=16'h00FF, carry=1 with `out_ready`=0 → the next cycle shows `out_valid`=1, `out_op`=2, `out_result`=16'h00FF, `out_carry`=1, `count`=1.
- Push 4 distinct results with no pops → `count`=4 and `in_ready`=0. A 5th push (result=16'hDEAD) → it is dropped, `overflow`=1, `count` stays 4. Pop ×4 → entries come out in push order and 16'hDEAD never appears.
- When full, assert push and pop in the same cycle → only the pop occurs, `count`=3, `in_ready`=1 the next cycle. At `count`=2, push+pop together → `count` stays 2 and order is preserved.
- Run 10 push/pop pairs with `DEPTH`=4 so the pointers wrap → every output matches its input in order, and `count` returns to 0 with `out_valid`=0 and all `out_*`=0.
- Assert `rst_n`=0 mid-cycle with 3 entries stored → `out_valid`, `count` and `overflow` drop to 0 without waiting for a clock edge. After release, the first push is the first entry seen at the output.
- With `ALU_RES_ZERO_FLAG_EN`, push result=16'h0000 then 16'h0001 → `out_zero`=1 then 0. Assert `clr_ovf` after an overflow → `overflow`=0 on the next edge.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffered result stage behind the 8-bit ALU.
// Captures {opcode, 2*DATA_W-bit result, carry} on a valid/ready push and presents
// entries in order on a first-word-fall-through valid/ready pop interface.
// A push attempted while full is dropped and sets a sticky overflow flag.
// Optional feature macro: ALU_RES_ZERO_FLAG_EN adds a stored "result was zero"
// bit per entry and the out_zero port.

module alu_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // push side (from the ALU)
  input  logic                      in_valid,
  input  logic [3:0]                in_op,
  input  logic [2*DATA_W-1:0]       in_result,
  input  logic                      in_carry,
  output logic                      in_ready,
  // pop side (to the consumer)
  output logic                      out_valid,
  output logic [3:0]                out_op,
  output logic [2*DATA_W-1:0]       out_result,
  output logic                      out_carry,
`ifdef ALU_RES_ZERO_FLAG_EN
  output logic                      out_zero,
`endif
  input  logic                      out_ready,
  // status
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = 2 * DATA_W;

  // Storage; contents are deliberately not reset, only the pointers are.
  logic [3:0]    r_mem_op     [DEPTH];
  logic [RW-1:0] r_mem_result [DEPTH];
  logic          r_mem_carry  [DEPTH];
`ifdef ALU_RES_ZERO_FLAG_EN
  logic          r_mem_zero   [DEPTH];
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic          r_overflow;

  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [PW-1:0] w_count_nxt;
  logic          w_overflow_nxt;

  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  assign w_waddr = r_wptr[AW-1:0];
  assign w_raddr = r_rptr[AW-1:0];

  // Full when the low bits match but the pointers are on different laps.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // No pass-through when full: a pop in the same cycle does not make room.
  assign w_push = in_valid && !w_full;
  assign w_pop  = out_ready && !w_empty;
  assign w_drop = in_valid && w_full;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Next-state for pointers, occupancy count and the sticky overflow flag.
  always_comb begin
    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;

    if (w_push) begin
      w_wptr_nxt = r_wptr + PW'(1);
    end
    if (w_pop) begin
      w_rptr_nxt = r_rptr + PW'(1);
    end

    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + PW'(1);
      2'b01:   w_count_nxt = r_count - PW'(1);
      default: w_count_nxt = r_count;
    endcase

    // A dropped push takes priority over a coincident clear.
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (clr_ovf) begin
      w_overflow_nxt = 1'b0;
    end
  end

  // Control state with asynchronous reset; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Entry write on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[w_waddr]     <= in_op;
      r_mem_result[w_waddr] <= in_result;
      r_mem_carry[w_waddr]  <= in_carry;
`ifdef ALU_RES_ZERO_FLAG_EN
      r_mem_zero[w_waddr]   <= (in_result == '0);
`endif
    end
  end

  // Head entry onto the outputs, forced to zero while empty.
  always_comb begin
    out_op     = 4'h0;
    out_result = '0;
    out_carry  = 1'b0;
`ifdef ALU_RES_ZERO_FLAG_EN
    out_zero   = 1'b0;
`endif
    if (!w_empty) begin
      out_op     = r_mem_op[w_raddr];
      out_result = r_mem_result[w_raddr];
      out_carry  = r_mem_carry[w_raddr];
`ifdef ALU_RES_ZERO_FLAG_EN
      out_zero   = r_mem_zero[w_raddr];
`endif
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: queue-based reference model compared every
// negative clock edge, plus directed vectors with literal expectations.
// Build with ALU_RES_ZERO_FLAG_EN defined to also exercise out_zero.

module tb_alu_result_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned RW     = 2 * DATA_W;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_op = 4'h0;
  logic [RW-1:0] in_result = '0;
  logic          in_carry = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [3:0]    out_op;
  logic [RW-1:0] out_result;
  logic          out_carry;
`ifdef ALU_RES_ZERO_FLAG_EN
  logic          out_zero;
`endif
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  alu_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_op     (out_op),
    .out_result (out_result),
    .out_carry  (out_carry),
`ifdef ALU_RES_ZERO_FLAG_EN
    .out_zero   (out_zero),
`endif
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an ordered queue of entries plus a sticky flag.
  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] res;
    logic          c;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model_b
    int   n;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_ovf <= 1'b0;
    end else begin
      n = q.size();
      if (in_valid && n == DEPTH) m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
      if (out_ready && n > 0) q.pop_front();
      if (in_valid && n < DEPTH) begin
        e.op = in_op;
        e.res = in_result;
        e.c = in_carry;
        q.push_back(e);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : cmp_b
    ent_t h;
    h = '0;
    if (q.size() != 0) h = q[0];
    chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_out_op", 32'(out_op), 32'(h.op));
    chk("m_out_result", 32'(out_result), 32'(h.res));
    chk("m_out_carry", 32'(out_carry), 32'(h.c));
`ifdef ALU_RES_ZERO_FLAG_EN
    chk("m_out_zero", 32'(out_zero), 32'(q.size() != 0 && h.res == '0));
`endif
  end

  logic [RW-1:0] popped[$];

  // One clock of stimulus; records the head when this cycle pops it.
  task automatic step(input logic v, input logic [3:0] op, input logic [RW-1:0] res,
                      input logic c, input logic ordy, input logic clr);
    in_valid  = v;
    in_op     = op;
    in_result = res;
    in_carry  = c;
    out_ready = ordy;
    clr_ovf   = clr;
    if (ordy && out_valid) popped.push_back(out_result);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic chk_popped(input string name, input logic [RW-1:0] exp[$]);
    chk({name, "_n"}, 32'(popped.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < popped.size()) chk(name, 32'(popped[i]), 32'(exp[i]));
    end
    popped.delete();
  endtask

  initial begin
    logic [RW-1:0] exp[$];

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible the cycle after the edge
    step(1'b1, 4'h2, 16'h00FF, 1'b1, 1'b0, 1'b0);
    chk("p1_out_valid", 32'(out_valid), 32'h1);
    chk("p1_out_op", 32'(out_op), 32'h2);
    chk("p1_out_result", 32'(out_result), 32'h00FF);
    chk("p1_out_carry", 32'(out_carry), 32'h1);
    chk("p1_count", 32'(count), 32'h1);

    // Fill, then an overflowing push
    step(1'b1, 4'h3, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h4, 16'h5678, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h5, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step(1'b1, 4'hF, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("drop_overflow", 32'(overflow), 32'h1);
    chk("drop_count", 32'(count), 32'h4);
    repeat (4) step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    exp = '{16'h00FF, 16'h1234, 16'h5678, 16'h9ABC};
    chk_popped("order1", exp);
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'h0);

    // Full with push+pop: only the pop happens; overflow set beats clear
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), RW'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hE, 16'h0BAD, 1'b1, 1'b1, 1'b1);
    chk("fpp_count", 32'(count), 32'h3);
    chk("fpp_in_ready", 32'(in_ready), 32'h1);
    chk("fpp_overflow", 32'(overflow), 32'h1);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("c2_count", 32'(count), 32'h2);
    step(1'b1, 4'h5, 16'h0105, 1'b1, 1'b1, 1'b0);
    chk("c2pp_count", 32'(count), 32'h2);
    repeat (2) step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    exp = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
    chk_popped("order2", exp);
    chk("clr2_overflow", 32'(overflow), 32'h0);

    // Pointer wrap: 10 push/pop pairs
    step(1'b1, 4'h0, 16'h1000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, 4'(i), RW'(16'h1000 + i), i[0], 1'b1, 1'b0);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(RW'(16'h1000 + i));
    chk_popped("wrap", exp);
    chk("wrap_count", 32'(count), 32'h0);
    chk("wrap_out_valid", 32'(out_valid), 32'h0);
    chk("wrap_out_op", 32'(out_op), 32'h0);
    chk("wrap_out_result", 32'(out_result), 32'h0);
    chk("wrap_out_carry", 32'(out_carry), 32'h0);

    // Asynchronous reset with 3 entries and overflow set
    for (int i = 1; i <= 5; i++) step(1'b1, 4'h7, RW'(16'h2000 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    chk("pre_rst_count", 32'(count), 32'h3);
    chk("pre_rst_overflow", 32'(overflow), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_overflow", 32'(overflow), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 4'h9, 16'h7777, 1'b0, 1'b0, 1'b0);
    chk("post_rst_result", 32'(out_result), 32'h7777);
    chk("post_rst_count", 32'(count), 32'h1);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    popped.delete();

`ifdef ALU_RES_ZERO_FLAG_EN
    step(1'b1, 4'h1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h1, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("zero_first", 32'(out_zero), 32'h1);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("zero_second", 32'(out_zero), 32'h0);
    step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("zero_empty", 32'(out_zero), 32'h0);
    popped.delete();
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
